// File: rtl/ccip_mmio_requester.sv
//==============================================================================
// Module      : ccip_mmio_requester
// Description : Single-outstanding CCI-P MMIO requester with tid tracking,
//               read timeout and stray-response counting.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ccip_mmio_requester #(
  parameter int TIMEOUT_CYCLES = 512,
  parameter int TID_WIDTH      = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [15:0]          cmd_addr,
  input  logic [63:0]          cmd_wdata,
  output logic                 rsp_valid,
  output logic [63:0]          rsp_rdata,
  output logic                 rsp_timeout,
  output logic                 c0_mmioWrValid,
  output logic                 c0_mmioRdValid,
  output logic [15:0]          c0_address,
  output logic [1:0]           c0_length,
  output logic [TID_WIDTH-1:0] c0_tid,
  output logic [63:0]          c0_data,
  input  logic                 c2_mmioRdValid,
  input  logic [TID_WIDTH-1:0] c2_tid,
  input  logic [63:0]          c2_data,
  output logic [7:0]           stray_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  localparam logic [15:0]          WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [TID_WIDTH-1:0] TID_ONE   = TID_WIDTH'(1);

  state_t                 state_q, state_d;
  logic                   init_q;
  logic                   write_q, write_d;
  logic [15:0]            addr_q, addr_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [TID_WIDTH-1:0]   tid_cnt_q, tid_cnt_d;
  logic [63:0]            data_q, data_d;
  logic [15:0]            wait_q, wait_d;
  logic [63:0]            rdata_q, rdata_d;
  logic                   timeout_q, timeout_d;
  logic [7:0]             stray_q, stray_d;
  logic                   match;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = cmd_addr[0];

  // Only the response carrying the tid of the outstanding read counts as a match.
  assign match = c2_mmioRdValid && (state_q == WAIT_RSP) && (c2_tid == tid_q);

  assign cmd_ready      = (state_q == IDLE) && init_q;
  assign c0_mmioWrValid = (state_q == ISSUE) && write_q;
  assign c0_mmioRdValid = (state_q == ISSUE) && !write_q;
  assign c0_address     = addr_q;
  assign c0_length      = 2'b01;
  assign c0_tid         = tid_q;
  assign c0_data        = data_q;
  assign rsp_valid      = (state_q == COMPLETE);
  assign rsp_rdata      = rdata_q;
  assign rsp_timeout    = timeout_q;
  assign stray_cnt      = stray_q;

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    tid_d     = tid_q;
    tid_cnt_d = tid_cnt_q;
    data_d    = data_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    stray_d   = stray_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = ISSUE;
          write_d = cmd_write;
          addr_d  = {cmd_addr[15:1], 1'b0};
          data_d  = cmd_wdata;
          if (!cmd_write) begin
            tid_d = tid_cnt_q;
          end
        end
      end
      ISSUE: begin
        if (write_q) begin
          state_d   = COMPLETE;
          rdata_d   = 64'd0;
          timeout_d = 1'b0;
        end else begin
          state_d   = WAIT_RSP;
          wait_d    = 16'd0;
          tid_cnt_d = tid_cnt_q + TID_ONE;
        end
      end
      WAIT_RSP: begin
        // A match on the expiry cycle takes priority over the timeout.
        if (match) begin
          state_d   = COMPLETE;
          rdata_d   = c2_data;
          timeout_d = 1'b0;
        end else if (wait_q == WAIT_LAST) begin
          state_d   = COMPLETE;
          rdata_d   = {64{1'b1}};
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (c2_mmioRdValid && !match && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      init_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= 16'd0;
      tid_q     <= '0;
      tid_cnt_q <= '0;
      data_q    <= 64'd0;
      wait_q    <= 16'd0;
      rdata_q   <= 64'd0;
      timeout_q <= 1'b0;
      stray_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      init_q    <= 1'b1;
      write_q   <= write_d;
      addr_q    <= addr_d;
      tid_q     <= tid_d;
      tid_cnt_q <= tid_cnt_d;
      data_q    <= data_d;
      wait_q    <= wait_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      stray_q   <= stray_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ccip_mmio_requester.sv
//==============================================================================
// Module      : tb_ccip_mmio_requester
// Description : Directed self-checking bench for ccip_mmio_requester.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ccip_mmio_requester;

  localparam int TO  = 16;
  localparam int TW  = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [15:0]   cmd_addr = 16'd0;
  logic [63:0]   cmd_wdata = 64'd0;
  logic          rsp_valid;
  logic [63:0]   rsp_rdata;
  logic          rsp_timeout;
  logic          c0_wr;
  logic          c0_rd;
  logic [15:0]   c0_address;
  logic [1:0]    c0_length;
  logic [TW-1:0] c0_tid;
  logic [63:0]   c0_data;
  logic          c2_valid = 1'b0;
  logic [TW-1:0] c2_tid = '0;
  logic [63:0]   c2_data = 64'd0;
  logic [7:0]    stray_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int lat;

  ccip_mmio_requester #(.TIMEOUT_CYCLES(TO), .TID_WIDTH(TW)) dut (
    .clk            (clk),
    .reset_n        (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_timeout    (rsp_timeout),
    .c0_mmioWrValid (c0_wr),
    .c0_mmioRdValid (c0_rd),
    .c0_address     (c0_address),
    .c0_length      (c0_length),
    .c0_tid         (c0_tid),
    .c0_data        (c0_data),
    .c2_mmioRdValid (c2_valid),
    .c2_tid         (c2_tid),
    .c2_data        (c2_data),
    .stray_cnt      (stray_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns one cycle after acceptance (the issue cycle).
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [63:0] wd);
    check("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = 16'hFFFF;
    cmd_wdata = 64'h5A5A_5A5A_5A5A_5A5A;
    cmd_write = ~wr;
  endtask

  task automatic wait_rsp(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic respond(input logic [TW-1:0] t, input logic [63:0] d);
    c2_valid = 1'b1;
    c2_tid   = t;
    c2_data  = d;
    tick();
    c2_valid = 1'b0;
    c2_data  = 64'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_c0_wr", c0_wr, 1'b0);
    check("rst_c0_rd", c0_rd, 1'b0);
    check("rst_c0_addr", c0_address, 16'h0);
    check("rst_c0_tid", c0_tid, 9'h0);
    check("rst_c0_data", c0_data, 64'h0);
    check("rst_rdata", rsp_rdata, 64'h0);
    check("rst_timeout", rsp_timeout, 1'b0);
    check("rst_stray", stray_cnt, 8'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", cmd_ready, 1'b1);

    // Write: c0 pulse at T+1, completion at T+2
    issue(1'b1, 16'h0048, 64'hDEAD_BEEF_0123_4567);
    check("wr_c0_wr", c0_wr, 1'b1);
    check("wr_c0_rd", c0_rd, 1'b0);
    check("wr_c0_addr", c0_address, 16'h0048);
    check("wr_c0_len", c0_length, 2'b01);
    check("wr_c0_data", c0_data, 64'hDEAD_BEEF_0123_4567);
    check("wr_ready_busy", cmd_ready, 1'b0);
    check("wr_rsp_early", rsp_valid, 1'b0);
    tick();
    check("wr_rsp_valid", rsp_valid, 1'b1);
    check("wr_rdata", rsp_rdata, 64'h0);
    check("wr_timeout", rsp_timeout, 1'b0);
    check("wr_c0_wr_drop", c0_wr, 1'b0);
    check("wr_c0_data_hold", c0_data, 64'hDEAD_BEEF_0123_4567);
    check("wr_ready_cmpl", cmd_ready, 1'b0);
    tick();
    check("wr_rsp_drop", rsp_valid, 1'b0);

    // Read with 2-cycle responder, tid 0
    issue(1'b0, 16'h0008, 64'h0);
    check("rd0_c0_rd", c0_rd, 1'b1);
    check("rd0_c0_wr", c0_wr, 1'b0);
    check("rd0_addr", c0_address, 16'h0008);
    check("rd0_tid", c0_tid, 9'd0);
    tick();
    check("rd0_c0_rd_drop", c0_rd, 1'b0);
    check("rd0_no_rsp", rsp_valid, 1'b0);
    tick();
    respond(9'd0, 64'hB74F_291A_F34E_1783);
    check("rd0_rsp_valid", rsp_valid, 1'b1);
    check("rd0_rdata", rsp_rdata, 64'hB74F_291A_F34E_1783);
    check("rd0_timeout", rsp_timeout, 1'b0);
    check("rd0_stray", stray_cnt, 8'd0);
    tick();

    // Read tid 1 with odd address, never answered -> timeout at T+18
    issue(1'b0, 16'h0011, 64'h0);
    check("rd1_tid", c0_tid, 9'd1);
    check("rd1_addr_align", c0_address, 16'h0010);
    wait_rsp(40, lat);
    check("to_latency", lat, 17);
    check("to_flag", rsp_timeout, 1'b1);
    check("to_rdata", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("to_rdata_hold", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    respond(9'd1, 64'h1234);
    check("late_stray", stray_cnt, 8'd1);

    // Wrong tid then correct tid
    issue(1'b0, 16'h0100, 64'h0);
    check("rd2_tid", c0_tid, 9'd2);
    tick();
    respond(9'd5, 64'hBAD0_BAD0_BAD0_BAD0);
    check("wrong_no_rsp", rsp_valid, 1'b0);
    respond(9'd2, 64'h1122_3344_5566_7788);
    check("wrong_then_ok_valid", rsp_valid, 1'b1);
    check("wrong_then_ok_data", rsp_rdata, 64'h1122_3344_5566_7788);
    check("wrong_then_ok_to", rsp_timeout, 1'b0);
    check("wrong_stray", stray_cnt, 8'd2);
    tick();

    // Match on the expiry cycle wins
    issue(1'b0, 16'h0200, 64'h0);
    check("rd3_tid", c0_tid, 9'd3);
    for (int i = 0; i < TO; i++) tick();
    check("exp_no_rsp_yet", rsp_valid, 1'b0);
    respond(9'd3, 64'hCAFE_F00D_0000_0001);
    check("exp_valid", rsp_valid, 1'b1);
    check("exp_data", rsp_rdata, 64'hCAFE_F00D_0000_0001);
    check("exp_to", rsp_timeout, 1'b0);
    check("exp_stray", stray_cnt, 8'd2);
    tick();

    // 512 reads: tid runs 4..511 then wraps to 0..3
    for (int i = 0; i < 512; i++) begin
      logic [TW-1:0] et;
      et = TW'((4 + i) % 512);
      issue(1'b0, 16'h0300, 64'h0);
      check("loop_tid", c0_tid, et);
      tick();
      respond(et, 64'(i));
      check("loop_rsp", rsp_valid, 1'b1);
      tick();
    end
    issue(1'b0, 16'h0300, 64'h0);
    check("wrap_next_tid", c0_tid, 9'd4);
    tick();
    respond(9'd4, 64'h77);
    check("wrap_next_rsp", rsp_rdata, 64'h77);
    tick();

    // Stray saturation
    c2_valid = 1'b1;
    c2_tid   = 9'd0;
    for (int i = 0; i < 252; i++) tick();
    check("stray_254", stray_cnt, 8'd254);
    for (int i = 0; i < 48; i++) tick();
    check("stray_sat", stray_cnt, 8'd255);
    c2_valid = 1'b0;

    // Reset during WAIT_RSP
    issue(1'b0, 16'h0400, 64'h0);
    check("rd_rst_tid", c0_tid, 9'd5);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_c0_rd", c0_rd, 1'b0);
    check("mid_rst_addr", c0_address, 16'h0);
    check("mid_rst_tid", c0_tid, 9'h0);
    check("mid_rst_rdata", rsp_rdata, 64'h0);
    check("mid_rst_to", rsp_timeout, 1'b0);
    check("mid_rst_stray", stray_cnt, 8'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hold_no_rsp", rsp_valid, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    check("rel_ready", cmd_ready, 1'b1);
    check("rel_no_rsp", rsp_valid, 1'b0);
    respond(9'd5, 64'h99);
    check("rel_late_stray", stray_cnt, 8'd1);
    check("rel_late_no_rsp", rsp_valid, 1'b0);
    issue(1'b0, 16'h0008, 64'h0);
    check("rel_tid_zero", c0_tid, 9'd0);
    tick();
    respond(9'd0, 64'hABCD);
    check("rel_rsp_data", rsp_rdata, 64'hABCD);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
